// File: rtl/bash_hash_stream_loader.sv
// Packs a 32-bit word stream into 1024-bit x blocks for bash_hash.
// Single-entry block buffer with valid/ready handoff and zero-filled tails.
module bash_hash_stream_loader #(
   parameter int XLEN    = 32,
   parameter int X_WORDS = 32,
   parameter int CNT_W   = 6
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [XLEN-1:0]         s_tdata_i,
   input  logic                    s_tvalid_i,
   output logic                    s_tready_o,
   input  logic                    s_tlast_i,
   output logic [XLEN*X_WORDS-1:0] x_o,
   output logic                    blk_valid_o,
   input  logic                    blk_ready_i,
   output logic                    blk_first_o,
   output logic                    blk_last_o,
   output logic [CNT_W-1:0]        blk_words_o
);

   typedef enum logic {FILL, FULL} state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q;
   logic [XLEN*X_WORDS-1:0]   x_q;
   logic [CNT_W-1:0]          words_q;
   logic                      last_q;
   logic                      first_q;
   logic                      msg_start_q;
   logic                      accept;
   logic                      blk_done;
   logic                      handoff;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= FILL;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      blk_done = 1'b0;
      handoff  = 1'b0;
      unique case (state_q)
         FILL: begin
            accept   = s_tvalid_i;
            blk_done = s_tvalid_i &&
                       (cnt_q == CNT_W'(X_WORDS - 1) || s_tlast_i);
            if (blk_done) state_d = FULL;
         end
         FULL: begin
            handoff = blk_ready_i;
            if (blk_ready_i) state_d = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   // Clearing on handoff is what zero-fills the unused tail slots.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_q         <= '0;
         cnt_q       <= '0;
         words_q     <= '0;
         last_q      <= 1'b0;
         first_q     <= 1'b1;
         msg_start_q <= 1'b1;
      end else if (accept) begin
         x_q[int'(cnt_q)*XLEN +: XLEN] <= s_tdata_i;
         if (blk_done) begin
            cnt_q   <= '0;
            words_q <= cnt_q + 1'b1;
            last_q  <= s_tlast_i;
            first_q <= msg_start_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else if (handoff) begin
         x_q         <= '0;
         cnt_q       <= '0;
         msg_start_q <= last_q;
      end
   end

   assign s_tready_o  = (state_q == FILL);
   assign blk_valid_o = (state_q == FULL);
   assign x_o         = x_q;
   assign blk_first_o = first_q;
   assign blk_last_o  = last_q;
   assign blk_words_o = words_q;

endmodule

// File: tb/tb_bash_hash_stream_loader.sv
// Directed bench for bash_hash_stream_loader: message table plus
// hand-written hold, reset-in-FULL and ignored-ready sequences.
module tb_bash_hash_stream_loader;

   localparam int XLEN = 32;
   localparam int XW   = 32;
   localparam int CW   = 6;
   localparam int BW   = XLEN * XW;

   logic            clk = 1'b0;
   logic            rst_i;
   logic [XLEN-1:0] s_tdata_i;
   logic            s_tvalid_i;
   logic            s_tready_o;
   logic            s_tlast_i;
   logic [BW-1:0]   x_o;
   logic            blk_valid_o;
   logic            blk_ready_i;
   logic            blk_first_o;
   logic            blk_last_o;
   logic [CW-1:0]   blk_words_o;

   bash_hash_stream_loader #(.XLEN(XLEN), .X_WORDS(XW), .CNT_W(CW)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .s_tdata_i  (s_tdata_i),
      .s_tvalid_i (s_tvalid_i),
      .s_tready_o (s_tready_o),
      .s_tlast_i  (s_tlast_i),
      .x_o        (x_o),
      .blk_valid_o(blk_valid_o),
      .blk_ready_i(blk_ready_i),
      .blk_first_o(blk_first_o),
      .blk_last_o (blk_last_o),
      .blk_words_o(blk_words_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BW-1:0] x;
      logic [CW-1:0] w;
      logic          f;
      logic          l;
   } blk_t;

   typedef struct {
      int          n;
      logic [31:0] base;
      bit          gaps;
      int          exp_nblk;
   } msg_t;

   blk_t cap[$];
   int   checks = 0;
   int   failures = 0;

   always @(negedge clk) begin
      if (!rst_i && blk_valid_o && blk_ready_i)
         cap.push_back('{x_o, blk_words_o, blk_first_o, blk_last_o});
   end

   function automatic void chk(string nm, logic [BW-1:0] got,
                               logic [BW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(logic [31:0] d, logic l);
      bit ok;
      int t = 0;
      s_tvalid_i = 1'b1;
      s_tdata_i  = d;
      s_tlast_i  = l;
      forever begin
         ok = s_tready_o;
         step();
         if (ok) break;
         t++;
         if (t > 200) begin
            chk("send_timeout", 1, 0);
            break;
         end
      end
      s_tvalid_i = 1'b0;
      s_tlast_i  = 1'b0;
   endtask

   task automatic send_msg(int n, logic [31:0] base, bit gaps, bit tl);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            while ($urandom_range(1) == 0) step();
         end
         send_word(base + 32'(i), tl && (i == n - 1));
      end
   endtask

   task automatic wait_blocks(int nb);
      int t = 0;
      while (cap.size() < nb && t < 100) begin
         step();
         t++;
      end
      chk("blk_count", cap.size(), nb);
   endtask

   function automatic logic [BW-1:0] model_x(logic [31:0] base,
                                             int lo, int hi);
      logic [BW-1:0] x = '0;
      for (int k = lo; k < hi; k++)
         x[(k-lo)*XLEN +: XLEN] = base + 32'(k);
      return x;
   endfunction

   msg_t tbl[7];

   initial begin
      logic [BW-1:0] ex;
      logic [BW-1:0] hold_x;
      int hi;

      tbl[0] = '{5,  32'h0000_00A0, 1'b0, 1};
      tbl[1] = '{40, 32'h1000_0000, 1'b0, 2};
      tbl[2] = '{10, 32'h2000_0000, 1'b0, 1};
      tbl[3] = '{10, 32'h2000_0000, 1'b1, 1};
      tbl[4] = '{32, 32'h3000_0000, 1'b0, 1};
      tbl[5] = '{1,  32'h4000_0000, 1'b0, 1};
      tbl[6] = '{33, 32'h5000_0000, 1'b1, 2};

      rst_i = 1'b1;
      s_tdata_i = '0;
      s_tvalid_i = 1'b0;
      s_tlast_i = 1'b0;
      blk_ready_i = 1'b0;
      step();
      step();
      rst_i = 1'b0;
      chk("rst_tready", s_tready_o, 1);
      chk("rst_valid", blk_valid_o, 0);
      chk("rst_x", x_o, 0);
      chk("rst_words", blk_words_o, 0);
      chk("rst_last", blk_last_o, 0);

      // Full block, consumer stalled: outputs must hold.
      send_msg(32, 32'h1, 1'b0, 1'b1);
      chk("hold_valid", blk_valid_o, 1);
      chk("hold_x0", x_o[31:0], 32'h1);
      chk("hold_x31", x_o[1023:992], 32'h20);
      chk("hold_words", blk_words_o, 32);
      chk("hold_first", blk_first_o, 1);
      chk("hold_last", blk_last_o, 1);
      chk("hold_tready", s_tready_o, 0);
      hold_x = x_o;
      s_tvalid_i = 1'b1;
      s_tdata_i  = 32'hDEAD_BEEF;
      repeat (6) step();
      s_tvalid_i = 1'b0;
      chk("hold2_valid", blk_valid_o, 1);
      chk("hold2_tready", s_tready_o, 0);
      chk("hold2_x", x_o, hold_x);
      chk("hold2_words", blk_words_o, 32);
      blk_ready_i = 1'b1;
      step();
      blk_ready_i = 1'b0;
      chk("ho_valid", blk_valid_o, 0);
      chk("ho_tready", s_tready_o, 1);
      chk("ho_x", x_o, 0);

      // Table of messages with an always-ready consumer.
      blk_ready_i = 1'b1;
      foreach (tbl[m]) begin
         cap.delete();
         send_msg(tbl[m].n, tbl[m].base, tbl[m].gaps, 1'b1);
         wait_blocks(tbl[m].exp_nblk);
         for (int b = 0; b < tbl[m].exp_nblk && b < cap.size(); b++) begin
            hi = (b + 1) * XW;
            if (hi > tbl[m].n) hi = tbl[m].n;
            ex = model_x(tbl[m].base, b * XW, hi);
            chk($sformatf("t%0d_b%0d_x", m, b), cap[b].x, ex);
            chk($sformatf("t%0d_b%0d_w", m, b), cap[b].w, hi - b * XW);
            chk($sformatf("t%0d_b%0d_f", m, b), cap[b].f, b == 0);
            chk($sformatf("t%0d_b%0d_l", m, b), cap[b].l,
                b == tbl[m].exp_nblk - 1);
         end
      end

      // Reset while a non-final block is pending.
      blk_ready_i = 1'b0;
      send_msg(32, 32'h6000_0000, 1'b0, 1'b0);
      chk("pend_valid", blk_valid_o, 1);
      chk("pend_last", blk_last_o, 0);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk("rstf_valid", blk_valid_o, 0);
      chk("rstf_x", x_o, 0);
      chk("rstf_tready", s_tready_o, 1);
      cap.delete();
      blk_ready_i = 1'b1;
      send_msg(2, 32'h7000_0000, 1'b0, 1'b1);
      wait_blocks(1);
      if (cap.size() > 0) begin
         chk("rstf_first", cap[0].f, 1);
         chk("rstf_words", cap[0].w, 2);
         chk("rstf_x2", cap[0].x, model_x(32'h7000_0000, 0, 2));
      end

      // blk_ready_i pulsed during FILL must be ignored.
      blk_ready_i = 1'b0;
      step();
      for (int i = 0; i < 12; i++) begin
         blk_ready_i = (i == 6);
         send_word(32'h8000_0000 + 32'(i), i == 11);
      end
      blk_ready_i = 1'b0;
      chk("ign_valid", blk_valid_o, 1);
      chk("ign_words", blk_words_o, 12);
      chk("ign_x", x_o, model_x(32'h8000_0000, 0, 12));
      chk("ign_first", blk_first_o, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bash_hash_stream_loader.md
Name: bash_hash_stream_loader

Overview:
- Upstream feeder for the bash_hash datapath.
- Accepts a 32-bit message word stream (valid/ready/last) and packs it into one 1024-bit x block in the same word order the datapath's x0..x15 inputs expect.
- Presents each completed block to the control side with first/last/word-count qualifiers, using a single-entry buffer with a valid/ready handoff.
- Zero-fills short final blocks. Padding bytes are the responsibility of the stream source.

Parameters:
XLEN, 32, stream word width in bits
X_WORDS, 32, words per block (X_WORDS*XLEN = 1024 = 16 x SLEN)
CNT_W, 6, width of word counter / blk_words_o; must hold X_WORDS

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
s_tdata_i  input  XLEN  message word
s_tvalid_i  input  1  word valid
s_tready_o  output  1  loader can accept word
s_tlast_i  input  1  word is final word of message
x_o  output  XLEN*X_WORDS  packed block; word k at x_o[k*XLEN +: XLEN]
blk_valid_o  output  1  x_o holds a complete block
blk_ready_i  input  1  consumer takes block this cycle
blk_first_o  output  1  block is first of its message
blk_last_o  output  1  block is last of its message
blk_words_o  output  CNT_W  valid words in block, 1..X_WORDS

Behaviour:
- Reset (rst_i=1 at clk edge):
  - state=FILL; x_o=0; word counter=0.
  - blk_valid_o=0, blk_last_o=0, blk_words_o=0.
  - s_tready_o=1 after reset deasserts.
  - msg_start flag=1, so blk_first_o=1 for the next block.
  - Reset takes effect in any state, including FULL with a block pending; the pending block is discarded.
- States:
  - FILL: s_tready_o=1, blk_valid_o=0.
  - FULL: s_tready_o=0, blk_valid_o=1.
- Word accept: when s_tvalid_i && s_tready_o, write s_tdata_i into word slot cnt; cnt increments.
- FILL -> FULL (the registered outputs below become visible in the first FULL cycle) when the accepted word has cnt==X_WORDS-1 or s_tlast_i=1:
  - blk_words_o=cnt+1.
  - blk_last_o=s_tlast_i.
  - blk_first_o=msg_start.
- Zero-fill: slots at index cnt+1 and above stay 0, because the buffer is cleared on every handoff.
- FULL hold: x_o and all blk_* outputs are held stable until blk_ready_i=1. No word is accepted while in FULL.
- Handoff (FULL and blk_ready_i=1):
  - Next cycle: state=FILL, x_o=0, cnt=0, blk_valid_o=0.
  - msg_start := blk_last_o.
  - s_tready_o=1 in that same next cycle.
  - Minimum block-to-block gap is one cycle after handoff.
- blk_ready_i in FILL is ignored.
- Throughput: 1 word/cycle while filling; X_WORDS+1 cycles minimum per block when the consumer is always ready.
- s_tlast_i on exactly word X_WORDS-1: produces a single block with blk_words_o=X_WORDS and blk_last_o=1. No empty trailing block is emitted.
- A message longer than X_WORDS words: the first block has blk_first_o=1, blk_last_o=0. Subsequent blocks have blk_first_o=0. The final block has blk_last_o=1.
- s_tvalid_i may toggle arbitrarily. Words are taken only on the handshake; gaps do not disturb cnt or x_o.
- Counter never exceeds X_WORDS-1; no wrap condition is reachable.

Test Plan:
- Reset, then 32 words 0x00000001..0x00000020 with tlast on the 32nd, blk_ready_i=0 -> blk_valid_o=1, x_o[31:0]=0x1, x_o[1023:992]=0x20, blk_words_o=32, first=1, last=1, s_tready_o=0 held indefinitely.
- 5-word message 0xA0..0xA4 with tlast on 0xA4 -> blk_words_o=5, x_o[159:128]=0xA4, bits 1023:160 all 0, first=1, last=1.
- 40-word message, blk_ready_i=1 always -> block1 first=1/last=0/words=32; one-cycle gap; block2 first=0/last=1/words=8 with slots 8..31 zero; then next message starts with first=1.
- Random s_tvalid_i gaps (50%) with 10-word message -> identical x_o and blk_words_o=10 as the gapless run; no word lost or duplicated.
- rst_i asserted in FULL with a 32-word block pending -> next cycle blk_valid_o=0, x_o=0, s_tready_o=1; the following block reports first=1.
- blk_ready_i pulsed during FILL at word 7 of 12 -> ignored; block completes at word 12 with words=12.
